// File: rtl/uart_tx_fifo_if.sv
// Byte producer / transmitter handshake bundle for uart_tx_fifo.
// The master side is the surrounding system (producer + transmitter), the slave side is the buffer.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_Sig;
  logic [DATA_WIDTH-1:0] wr_Data;
  logic                  tx_Busy;
  logic                  tx_Start;
  logic [DATA_WIDTH-1:0] tx_Data;

  modport master (
    output wr_Sig, wr_Data, tx_Busy,
    input  tx_Start, tx_Data
  );

  modport slave (
    input  wr_Sig, wr_Data, tx_Busy,
    output tx_Start, tx_Data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit buffer: circular FIFO released to the UART transmitter by a debounced button,
// one byte per press or a whole-queue burst, with status and sticky error flags.
module uart_tx_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int DEBOUNCE_TIME = 100,
  parameter int AFULL_LEVEL   = 6,
  parameter int AEMPTY_LEVEL  = 2
) (
  input  logic                 sample_Clk,
  input  logic                 reset,
  input  logic                 button_Trig,
  input  logic                 mode_Burst,
  input  logic                 clr_Err,
  uart_tx_fifo_if.slave        bus,
  output logic [ADDR_WIDTH:0]  fifo_Count,
  output logic                 sig_Full,
  output logic                 sig_Empty,
  output logic                 sig_AlmostFull,
  output logic                 sig_AlmostEmpty,
  output logic                 sig_Overflow,
  output logic                 sig_Underflow
);

  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
  localparam logic [14:0]         DEB_MAX  = 15'(DEBOUNCE_TIME);
  localparam logic [14:0]         DEB_EVT  = 15'(DEBOUNCE_TIME - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                 state, state_nx;
  logic [14:0]            deb_cnt;
  logic                   press_evt;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]    count;
  logic                   full, empty;
  logic                   push, pop;
  logic                   ovf_set, udf_set;
  logic                   tx_start_q;
  logic [DATA_WIDTH-1:0]  tx_data_q;
  logic                   ovf_q, udf_q;

  // Saturating low-time counter; the event fires once on the way up, so a long hold yields one press.
  always_ff @(posedge sample_Clk) begin
    if (reset)                deb_cnt <= '0;
    else if (button_Trig)     deb_cnt <= '0;
    else if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 15'd1;
  end

  assign press_evt = (deb_cnt == DEB_EVT);

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push    = bus.wr_Sig && !full;
  assign ovf_set = bus.wr_Sig && full;

  always_ff @(posedge sample_Clk) begin
    if (push) mem[wr_ptr] <= bus.wr_Data;
  end

  always_ff @(posedge sample_Clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sample_Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    udf_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_evt) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = WAIT_BUSY;
          end else begin
            udf_set  = 1'b1;
          end
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_Busy) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Burst mode is only looked at here, so dropping it mid-burst ends after the current byte.
        if (!bus.tx_Busy) begin
          if (mode_Burst && !empty) begin
            pop      = 1'b1;
            state_nx = WAIT_BUSY;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sample_Clk) begin
    if (reset) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= pop;
      if (pop) tx_data_q <= mem[rd_ptr];
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge sample_Clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~clr_Err);
      udf_q <= udf_set | (udf_q & ~clr_Err);
    end
  end

  assign bus.tx_Start    = tx_start_q;
  assign bus.tx_Data     = tx_data_q;
  assign fifo_Count      = count;
  assign sig_Full        = full;
  assign sig_Empty       = empty;
  assign sig_AlmostFull  = (count >= AFULL_C);
  assign sig_AlmostEmpty = (count <= AEMPTY_C);
  assign sig_Overflow    = ovf_q;
  assign sig_Underflow   = udf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, all outputs compared every cycle
// against a queue-based reference model of the buffer's behaviour.
module tb_uart_tx_fifo;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;
  localparam int DEB = 100;
  localparam int AFULL = 6;
  localparam int AEMPTY = 2;

  logic clk = 1'b0;
  logic reset, button_Trig, mode_Burst, clr_Err;
  logic [AW:0] fifo_Count;
  logic sig_Full, sig_Empty, sig_AlmostFull, sig_AlmostEmpty, sig_Overflow, sig_Underflow;

  uart_tx_fifo_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEBOUNCE_TIME(DEB),
    .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPTY)
  ) dut (
    .sample_Clk(clk), .reset(reset), .button_Trig(button_Trig), .mode_Burst(mode_Burst),
    .clr_Err(clr_Err), .bus(bus), .fifo_Count(fifo_Count), .sig_Full(sig_Full),
    .sig_Empty(sig_Empty), .sig_AlmostFull(sig_AlmostFull), .sig_AlmostEmpty(sig_AlmostEmpty),
    .sig_Overflow(sig_Overflow), .sig_Underflow(sig_Underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;

  // Reference model: queue of pending bytes and a transfer phase (0 none, 1 awaiting busy, 2 awaiting done).
  logic [DW-1:0] q[$];
  int            low_run = 0;
  int            ph = 0;
  logic          m_start = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  // Transmitter stand-in: busy one cycle after each start, for busy_len cycles.
  logic tx_pend = 1'b0;
  int   busy_left = 0;
  int   busy_len = 10;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  cnt0;
    bit  press, do_pop;
    if (reset) begin
      q.delete();
      low_run = 0; ph = 0;
      m_start = 1'b0; m_data = '0; m_ovf = 1'b0; m_udf = 1'b0;
      return;
    end
    press  = (low_run == DEB - 1);
    cnt0   = q.size();
    do_pop = 1'b0;
    m_udf  = m_udf & ~clr_Err;
    m_ovf  = m_ovf & ~clr_Err;
    if (ph == 0) begin
      if (press) begin
        if (cnt0 > 0) do_pop = 1'b1;
        else          m_udf = 1'b1;
      end
    end else if (ph == 1) begin
      if (bus.tx_Busy) ph = 2;
    end else begin
      if (!bus.tx_Busy) begin
        if (mode_Burst && cnt0 > 0) do_pop = 1'b1;
        else                        ph = 0;
      end
    end
    if (do_pop) begin
      m_data = q.pop_front();
      ph = 1;
    end
    m_start = do_pop;
    if (bus.wr_Sig) begin
      if (cnt0 == DEPTH) m_ovf = 1'b1;
      else               q.push_back(bus.wr_Data);
    end
    if (button_Trig) low_run = 0;
    else if (low_run < DEB) low_run++;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("tx_start", {31'd0, bus.tx_Start}, {31'd0, m_start});
    chk("tx_data", {24'd0, bus.tx_Data}, {24'd0, m_data});
    chk("count", {28'd0, fifo_Count}, n);
    chk("full", {31'd0, sig_Full}, {31'd0, n == DEPTH});
    chk("empty", {31'd0, sig_Empty}, {31'd0, n == 0});
    chk("afull", {31'd0, sig_AlmostFull}, {31'd0, n >= AFULL});
    chk("aempty", {31'd0, sig_AlmostEmpty}, {31'd0, n <= AEMPTY});
    chk("ovf", {31'd0, sig_Overflow}, {31'd0, m_ovf});
    chk("udf", {31'd0, sig_Underflow}, {31'd0, m_udf});
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    if (bus.tx_Start === 1'b1) n_pulse++;
    check_all();
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) bus.tx_Busy = 1'b0;
    end
    if (tx_pend) begin
      tx_pend = 1'b0;
      bus.tx_Busy = 1'b1;
      busy_left = busy_len;
    end
    if (m_start) tx_pend = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic write(input logic [DW-1:0] d);
    bus.wr_Sig = 1'b1;
    bus.wr_Data = d;
    cycle();
    bus.wr_Sig = 1'b0;
  endtask

  task automatic press(input int low_cycles);
    button_Trig = 1'b0;
    repeat (low_cycles) cycle();
    button_Trig = 1'b1;
    cycle();
  endtask

  task automatic wait_idle(input int max_cyc);
    bit reached = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (ph == 0 && !tx_pend && bus.tx_Busy == 1'b0) begin
        reached = 1'b1;
        break;
      end
      cycle();
    end
    chk("wait_idle", {31'd0, reached}, 32'd1);
  endtask

  initial begin
    int hold;
    reset = 1'b1; button_Trig = 1'b1; mode_Burst = 1'b0; clr_Err = 1'b0;
    bus.wr_Sig = 1'b0; bus.wr_Data = '0; bus.tx_Busy = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_count", {28'd0, fifo_Count}, 32'd0);
    chk("rst_empty", {31'd0, sig_Empty}, 32'd1);

    // Single-byte press
    write(8'h11); write(8'h22); write(8'h33);
    n_pulse = 0;
    press(DEB);
    wait_idle(40);
    chk("single_pulses", n_pulse, 32'd1);
    chk("single_count", {28'd0, fifo_Count}, 32'd2);

    // Burst of four
    do_reset();
    for (int i = 0; i < 4; i++) write(8'hA0 + 8'(i));
    mode_Burst = 1'b1;
    n_pulse = 0;
    press(DEB);
    repeat (5) cycle();
    wait_idle(200);
    chk("burst_pulses", n_pulse, 32'd4);
    chk("burst_empty", {31'd0, sig_Empty}, 32'd1);
    mode_Burst = 1'b0;

    // Overflow and clear
    do_reset();
    for (int i = 0; i < 9; i++) write(8'($urandom));
    chk("ovf_full", {31'd0, sig_Full}, 32'd1);
    chk("ovf_flag", {31'd0, sig_Overflow}, 32'd1);
    clr_Err = 1'b1; cycle(); clr_Err = 1'b0;
    chk("ovf_clr", {31'd0, sig_Overflow}, 32'd0);

    // Underflow, write racing an empty-FIFO press, and a short bounce
    do_reset();
    n_pulse = 0;
    press(DEB);
    chk("udf_flag", {31'd0, sig_Underflow}, 32'd1);
    clr_Err = 1'b1; cycle(); clr_Err = 1'b0;
    button_Trig = 1'b0;
    repeat (DEB - 1) cycle();
    bus.wr_Sig = 1'b1; bus.wr_Data = 8'h5C;
    cycle();
    bus.wr_Sig = 1'b0; button_Trig = 1'b1;
    cycle();
    chk("udf_race", {31'd0, sig_Underflow}, 32'd1);
    press(50);
    repeat (5) cycle();
    chk("bounce_pulses", n_pulse, 32'd0);

    // Simultaneous push and pop at count 4
    do_reset();
    for (int i = 0; i < 4; i++) write(8'($urandom));
    button_Trig = 1'b0;
    repeat (DEB - 1) cycle();
    bus.wr_Sig = 1'b1; bus.wr_Data = 8'h7E;
    cycle();
    bus.wr_Sig = 1'b0; button_Trig = 1'b1;
    chk("simul_count", {28'd0, fifo_Count}, 32'd4);
    wait_idle(40);

    // Pointer wrap over 20 write/press rounds
    for (int i = 0; i < 20; i++) begin
      busy_len = int'($urandom_range(2, 10));
      write(8'($urandom));
      press(DEB);
      wait_idle(40);
    end
    busy_len = 10;

    // Reset one cycle after a burst start
    do_reset();
    for (int i = 0; i < 6; i++) write(8'($urandom));
    mode_Burst = 1'b1;
    button_Trig = 1'b0;
    hold = 0;
    for (int i = 0; i < 200 && !m_start; i++) begin
      if (i > DEB) button_Trig = 1'b1;
      cycle();
    end
    button_Trig = 1'b1;
    chk("rstb_started", {31'd0, m_start}, 32'd1);
    cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("rstb_start", {31'd0, bus.tx_Start}, 32'd0);
    chk("rstb_count", {28'd0, fifo_Count}, 32'd0);
    n_pulse = 0;
    repeat (40) cycle();
    chk("rstb_pulses", n_pulse, 32'd0);
    mode_Burst = 1'b0;

    // Random traffic
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.wr_Sig = ($urandom_range(0, 3) == 0);
      bus.wr_Data = 8'($urandom);
      clr_Err = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 200) == 0) mode_Burst = ~mode_Burst;
      if ($urandom_range(0, 30) == 0) busy_len = int'($urandom_range(1, 12));
      if (hold > 0) begin
        button_Trig = 1'b0;
        hold--;
      end else begin
        button_Trig = 1'b1;
        if ($urandom_range(0, 40) == 0) hold = int'($urandom_range(20, 140));
      end
      reset = ($urandom_range(0, 1500) == 0);
      cycle();
    end
    bus.wr_Sig = 1'b0; clr_Err = 1'b0; reset = 1'b0; button_Trig = 1'b1;
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised transmit buffer for the UART path. It sits between the byte producer and the UART transmitter. Incoming bytes are queued in a circular FIFO of configurable width and depth, and a debounced push-button releases them to the transmitter, one byte per press or the whole queue per press in burst mode. Unlike the previous buffer it adds:
- a `tx_Busy` handshake with the transmitter;
- a registered `tx_Data` output;
- occupancy count and almost-full/almost-empty flags;
- sticky overflow/underflow error flags.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each FIFO entry and of `tx_Data`
- `ADDR_WIDTH`, 3, pointer width; depth `DEPTH` = 2^`ADDR_WIDTH`
- `DEBOUNCE_TIME`, 100, number of `sample_Clk` cycles `button_Trig` must stay low to register a press (≥2)
- `AFULL_LEVEL`, 6, `sig_AlmostFull` = (count ≥ `AFULL_LEVEL`)
- `AEMPTY_LEVEL`, 2, `sig_AlmostEmpty` = (count ≤ `AEMPTY_LEVEL`)

Ports:
- `sample_Clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `button_Trig`  in  1  push-button, active-low, already synchronised
- `mode_Burst`  in  1  0: one byte per press; 1: drain the FIFO per press
- `wr_Sig`  in  1  write strobe, one entry per high cycle
- `wr_Data`  in  `DATA_WIDTH`  write data
- `tx_Busy`  in  1  transmitter busy (high while shifting a byte)
- `clr_Err`  in  1  clears the sticky error flags
- `tx_Start`  out  1  one-cycle start pulse to the transmitter
- `tx_Data`  out  `DATA_WIDTH`  registered byte; valid from the `tx_Start` cycle until the next pop
- `fifo_Count`  out  `ADDR_WIDTH`+1  occupancy, 0..`DEPTH`
- `sig_Full`, `sig_Empty`, `sig_AlmostFull`, `sig_AlmostEmpty`  out  1 each  status flags, all derived from `fifo_Count`
- `sig_Overflow`, `sig_Underflow`  out  1 each  sticky error flags

## Operation
**Debounce**
- 15-bit counter: increments while `button_Trig`=0, saturates at `DEBOUNCE_TIME`, clears to 0 when `button_Trig`=1.
- `press_Evt` is asserted combinationally when the counter equals `DEBOUNCE_TIME`-1. This gives exactly one event per press regardless of how long the button is held.

**FIFO**
- `DEPTH` entries, separate read and write pointers. Pointers wrap naturally modulo `DEPTH`.
- Memory is not reset and has no preload.
- Write is accepted iff `wr_Sig`=1 and count ≠ `DEPTH`, both evaluated at the start of the cycle.
- `wr_Sig`=1 while full: the data is dropped and `sig_Overflow` is set. This holds even if a pop occurs in the same cycle.
- Push and pop in the same cycle: `fifo_Count` is unchanged and both pointers advance.

**State machine**
- IDLE
  - On `press_Evt`, if not empty: pop.
  - On `press_Evt`, if empty: set `sig_Underflow` and stay in IDLE.
- Pop action (single edge): `tx_Data` ← mem[rd_Ptr]; rd_Ptr+1; `tx_Start` ← 1 for one cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for `tx_Busy`=1, then go to WAIT_DONE. There is no timeout; the transmitter must acknowledge.
- WAIT_DONE: when `tx_Busy`=0:
  - if `mode_Burst`=1 and not empty: pop again (go to WAIT_BUSY);
  - otherwise go to IDLE.
- `press_Evt` outside IDLE is ignored and not queued.
- `mode_Burst` is sampled only in WAIT_DONE. Clearing it mid-burst stops the burst after the current byte.

**Error flags**
- `clr_Err`=1 clears both sticky flags.
- If a flag's set condition occurs in the same cycle as `clr_Err`, set wins.

## Timing
- Reset values:
  - `tx_Start`=0, `tx_Data`=0, `fifo_Count`=0
  - `sig_Empty`=1, `sig_AlmostEmpty`=1, `sig_Full`=0, `sig_AlmostFull`=0
  - `sig_Overflow`=0, `sig_Underflow`=0
  - state IDLE, debounce counter 0, both pointers 0
- Reset mid-operation: on the next edge the FIFO is flushed, the burst is aborted and `tx_Start` goes to 0. A byte already in the transmitter is not recalled.
- Write at edge N: `fifo_Count` and the flags update at edge N; they are visible in cycle N+1.
- `press_Evt` in cycle N (in IDLE, FIFO non-empty at the start of cycle N): `tx_Start`=1 and `tx_Data` valid in cycle N+1.
- A write in the same cycle as `press_Evt` to an empty FIFO does not prevent underflow.
- Burst: the next `tx_Start` occurs one cycle after the cycle in which `tx_Busy` is sampled low in WAIT_DONE.
- `fifo_Count` width is `ADDR_WIDTH`+1, so `DEPTH` is representable. Full = count `DEPTH`; empty = count 0.

## Test plan
- Reset, then write 0x11,0x22,0x33; hold `button_Trig` low for 100 cycles → exactly one `tx_Start` with `tx_Data`=0x11; `fifo_Count`=2.
- `mode_Burst`=1, FIFO holds 0xA0..0xA3, one press; transmitter model raises `tx_Busy` 1 cycle after each `tx_Start` for 10 cycles → 4 pulses with data 0xA0,0xA1,0xA2,0xA3; then `sig_Empty`=1 and state IDLE.
- 9 writes with default depth → `sig_Full`=1 after 8 writes; 9th write dropped; `sig_Overflow`=1; `sig_AlmostFull` high from count 6. Then `clr_Err` → `sig_Overflow`=0.
- Press on empty FIFO → no `tx_Start`; `sig_Underflow`=1. Button bounce shorter than 100 cycles → no event.
- 20 write/press cycles → pointers wrap with data order preserved. Simultaneous write and pop at count 4 → count stays 4.
- Assert `reset` one cycle after `tx_Start` during a burst → all outputs return to reset values at the next edge; no further `tx_Start`.
